// File: rtl/instruction_memory_responder.sv
// ============================================================================
// Module  : instruction_memory_responder
// Purpose : Fetch-side responder that returns a 32-bit instruction from a
//           write-loadable word store after a fixed, parameterised latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_memory_responder #(
    parameter int          DEPTH      = 32,
    parameter logic [31:0] ADDR_LIMIT = 32'd127,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] ReqAddress,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] Instruction,
    output logic        AddrError,
    input  logic        WrEn,
    input  logic [4:0]  WrAddress,
    input  logic [31:0] WrData
);

    localparam int         IDX_W      = $clog2(DEPTH);
    localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_instr;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_capture;
    logic [31:0] w_cap_addr;
    logic        w_bad;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ReqValid) begin
                    w_accept   = 1'b1;
                    w_next_cnt = C_CNT_LOAD;
                    if (LATENCY == 1) begin
                        w_next_state = S_RESP;
                        w_capture    = 1'b1;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_RESP;
                    w_capture    = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (RespReady) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // A single-cycle latency captures on the accept edge, before r_addr is loaded
    assign w_cap_addr = (r_state == S_IDLE) ? ReqAddress : r_addr;
    assign w_bad      = (w_cap_addr > ADDR_LIMIT) || (w_cap_addr[1:0] != 2'b00);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_instr <= NOP_WORD;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_addr <= ReqAddress;
            end
            if (w_capture) begin
                r_err   <= w_bad;
                r_instr <= w_bad ? NOP_WORD : r_mem[w_cap_addr[IDX_W+1:2]];
            end
        end
    end

    // Store is deliberately outside reset so its contents survive a reset pulse
    always_ff @(posedge Clk) begin
        if (WrEn) begin
            r_mem[WrAddress] <= WrData;
        end
    end

    assign ReqReady    = (r_state == S_IDLE);
    assign RespValid   = (r_state == S_RESP);
    assign Instruction = r_instr;
    assign AddrError   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instruction_memory_responder.sv
// ============================================================================
// Module  : tb_instruction_memory_responder
// Purpose : Directed self-checking bench for instruction_memory_responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_memory_responder;

    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic [31:0] ReqAddress = 32'd0;
    logic        RespValid;
    logic        RespReady = 1'b1;
    logic [31:0] Instruction;
    logic        AddrError;
    logic        WrEn = 1'b0;
    logic [4:0]  WrAddress = 5'd0;
    logic [31:0] WrData = 32'd0;

    int errors = 0;
    int checks = 0;

    instruction_memory_responder #(
        .DEPTH      (32),
        .ADDR_LIMIT (32'd127),
        .LATENCY    (LAT),
        .NOP_WORD   (32'h0000_0000)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqAddress  (ReqAddress),
        .RespValid   (RespValid),
        .RespReady   (RespReady),
        .Instruction (Instruction),
        .AddrError   (AddrError),
        .WrEn        (WrEn),
        .WrAddress   (WrAddress),
        .WrData      (WrData)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a response appears LAT edges after acceptance
    bit [31:0] m_mem [32];
    bit        m_busy = 1'b0;
    bit        m_resp = 1'b0;
    bit [31:0] m_addr = 32'd0;
    bit [31:0] m_instr = 32'd0;
    bit        m_err = 1'b0;
    longint    m_cyc = 0;
    longint    m_acc = 0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_busy  = 1'b0;
            m_resp  = 1'b0;
            m_instr = 32'd0;
            m_err   = 1'b0;
        end else begin
            if (m_resp && RespReady) begin
                m_resp = 1'b0;
                m_busy = 1'b0;
            end else if (m_busy && !m_resp && (m_cyc == m_acc + LAT)) begin
                m_resp = 1'b1;
                if (m_addr > 127 || (m_addr % 4) != 0) begin
                    m_err   = 1'b1;
                    m_instr = 32'd0;
                end else begin
                    m_err   = 1'b0;
                    m_instr = m_mem[m_addr / 4];
                end
            end else if (!m_busy && ReqValid) begin
                m_busy = 1'b1;
                m_acc  = m_cyc;
                m_addr = ReqAddress;
            end
            if (WrEn) m_mem[WrAddress] = WrData;
            m_cyc++;
        end
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            chk("model_req_ready", {31'd0, ReqReady}, {31'd0, !m_busy});
            chk("model_resp_valid", {31'd0, RespValid}, {31'd0, m_resp});
            if (m_resp) begin
                chk("model_instruction", Instruction, m_instr);
                chk("model_addr_error", {31'd0, AddrError}, {31'd0, m_err});
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_word(input logic [4:0] idx, input logic [31:0] data);
        WrEn = 1'b1; WrAddress = idx; WrData = data;
        step();
        WrEn = 1'b0;
    endtask

    // Issued from IDLE, so acceptance happens on the next edge
    task automatic request(input logic [31:0] addr);
        ReqValid = 1'b1; ReqAddress = addr;
        step();
        ReqValid = 1'b0; ReqAddress = 32'hFFFF_FFFF;
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (RespValid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        if (RespValid !== 1'b1) chk({name, "_timeout"}, {31'd0, RespValid}, 32'd1);
    endtask

    task automatic transact(input string name, input logic [31:0] addr,
                            input logic [31:0] exp_instr, input logic exp_err);
        int lat;
        RespReady = 1'b1;
        request(addr);
        wait_valid(name, lat);
        chk({name, "_latency"}, lat, LAT);
        chk({name, "_instr"}, Instruction, exp_instr);
        chk({name, "_err"}, {31'd0, AddrError}, {31'd0, exp_err});
        step();
    endtask

    initial begin
        int lat;
        #1;
        chk("reset_resp_valid", {31'd0, RespValid}, 32'd0);
        chk("reset_instr", Instruction, 32'd0);
        chk("reset_err", {31'd0, AddrError}, 32'd0);
        chk("reset_req_ready", {31'd0, ReqReady}, 32'd1);
        #11 Reset = 1'b0;
        step();

        for (int i = 0; i < 32; i++) write_word(5'(i), 32'hC0DE_0000 | 32'(i));
        write_word(5'd3, 32'h2008_0005);
        write_word(5'd31, 32'h1F1F_1F1F);

        transact("basic", 32'h0000_000C, 32'h2008_0005, 1'b0);

        // Consumer stall: response must hold steady
        RespReady = 1'b0;
        request(32'h0000_000C);
        wait_valid("stall", lat);
        chk("stall_latency", lat, LAT);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", {31'd0, RespValid}, 32'd1);
            chk("stall_instr", Instruction, 32'h2008_0005);
            chk("stall_req_ready", {31'd0, ReqReady}, 32'd0);
        end
        RespReady = 1'b1;
        step();
        chk("stall_release_ready", {31'd0, ReqReady}, 32'd1);
        chk("stall_release_valid", {31'd0, RespValid}, 32'd0);

        transact("over_limit", 32'h0000_0080, 32'h0, 1'b1);
        transact("misaligned", 32'h0000_007E, 32'h0, 1'b1);
        transact("top_word", 32'h0000_007C, 32'h1F1F_1F1F, 1'b0);

        // Write lands on the same edge the read is captured
        request(32'h0000_000C);
        step();
        WrEn = 1'b1; WrAddress = 5'd3; WrData = 32'hFFFF_FFFF;
        step();
        WrEn = 1'b0;
        chk("rbw_valid", {31'd0, RespValid}, 32'd1);
        chk("rbw_old_data", Instruction, 32'h2008_0005);
        step();
        transact("rbw_new_data", 32'h0000_000C, 32'hFFFF_FFFF, 1'b0);

        // Abort during WAIT
        request(32'h0000_000C);
        #3 Reset = 1'b1;
        #1;
        chk("wait_rst_valid", {31'd0, RespValid}, 32'd0);
        chk("wait_rst_ready", {31'd0, ReqReady}, 32'd1);
        #2 Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("wait_rst_no_resp", {31'd0, RespValid}, 32'd0);
        end
        transact("after_wait_rst", 32'h0000_000C, 32'hFFFF_FFFF, 1'b0);

        // Abort during RESP, asynchronously
        RespReady = 1'b0;
        request(32'h0000_0004);
        wait_valid("resp_rst", lat);
        #2 Reset = 1'b1;
        #1;
        chk("resp_rst_valid", {31'd0, RespValid}, 32'd0);
        chk("resp_rst_instr", Instruction, 32'd0);
        chk("resp_rst_err", {31'd0, AddrError}, 32'd0);
        chk("resp_rst_ready", {31'd0, ReqReady}, 32'd1);
        #2 Reset = 1'b0;
        RespReady = 1'b1;
        step();
        transact("persist_w3", 32'h0000_000C, 32'hFFFF_FFFF, 1'b0);
        transact("persist_w4", 32'h0000_0010, 32'hC0DE_0004, 1'b0);
        transact("word0", 32'h0000_0000, 32'hC0DE_0000, 1'b0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
